// File: rtl/mem_resp_stage.sv
// mem_resp_stage: MEM pipeline stage that waits for variable-latency data SRAM
// responses and drops responses that belong to flushed instructions.
// Ports: clk/reset (async, active high); EX side (ex_mem_valid, mem_allowin, in_*);
// SRAM response (data_sram_data_ok, data_sram_rdata); flush; WB side (mem_wb_valid,
// wb_allowin, out_*); ID forwarding (mem_fwd_*); outst_cnt.
// Optional: define MEM_PERF_CNT_EN to add perf_wait_cycles and perf_discards.
module mem_resp_stage #(
   parameter int XLEN      = 32,
   parameter int SIDE_W    = 112,
   parameter int MAX_OUTST = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_mem_valid,
   output logic              mem_allowin,
   input  logic              in_mem_req,
   input  logic              in_res_from_mem,
   input  logic              in_gr_we,
   input  logic [4:0]        in_dest,
   input  logic [2:0]        in_mem_type,
   input  logic [2:0]        in_addr_low,
   input  logic [XLEN-1:0]   in_alu_result,
   input  logic [SIDE_W-1:0] in_side,
   input  logic              data_sram_data_ok,
   input  logic [XLEN-1:0]   data_sram_rdata,
   input  logic              flush,
   output logic              mem_wb_valid,
   input  logic              wb_allowin,
   output logic              out_gr_we,
   output logic [4:0]        out_dest,
   output logic [XLEN-1:0]   out_final_result,
   output logic [SIDE_W-1:0] out_side,
   output logic              mem_fwd_valid,
   output logic [4:0]        mem_fwd_dest,
   output logic [XLEN-1:0]   mem_fwd_data,
   output logic              mem_fwd_busy,
   output logic [2:0]        outst_cnt
`ifdef MEM_PERF_CNT_EN
   ,
   output logic [31:0]       perf_wait_cycles,
   output logic [15:0]       perf_discards
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HAVE = 2'd2;

   logic [1:0]        state;
   logic              mem_valid;
   logic [2:0]        discard_cnt;
   logic [XLEN-1:0]   rdata_buf;
   logic              res_from_mem_r;
   logic              gr_we_r;
   logic [4:0]        dest_r;
   logic [2:0]        mem_type_r;
   logic [2:0]        addr_low_r;
   logic [XLEN-1:0]   alu_r;
   logic [SIDE_W-1:0] side_r;

   logic ready_go;
   logic at_limit;
   logic accept;
   logic wb_fire;
   logic drop;
   logic live;
   logic disc_inc;

   assign ready_go = (state == S_HAVE);
   assign at_limit = (outst_cnt == 3'(MAX_OUTST));

   assign mem_allowin = ~flush
                      & (~mem_valid | (ready_go & wb_allowin))
                      & ~(at_limit & in_mem_req);

   assign accept       = ex_mem_valid & mem_allowin;
   assign mem_wb_valid = mem_valid & ready_go & ~flush;
   assign wb_fire      = mem_wb_valid & wb_allowin;

   // Responses are in order: pending discards always own the oldest data_ok.
   assign drop = data_sram_data_ok & (discard_cnt != 3'd0);
   assign live = data_sram_data_ok & (discard_cnt == 3'd0)
               & mem_valid & (state == S_WAIT);
   // A flushed waiter leaves an orphan response, unless it is answered now.
   assign disc_inc = flush & mem_valid & (state == S_WAIT) & ~live;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         mem_valid <= 1'b0;
      end else if (flush) begin
         state     <= S_IDLE;
         mem_valid <= 1'b0;
      end else if (accept) begin
         state     <= in_mem_req ? S_WAIT : S_HAVE;
         mem_valid <= 1'b1;
      end else if (wb_fire) begin
         state     <= S_IDLE;
         mem_valid <= 1'b0;
      end else if (live) begin
         state     <= S_HAVE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outst_cnt   <= 3'd0;
         discard_cnt <= 3'd0;
      end else begin
         outst_cnt   <= outst_cnt + 3'(accept & in_mem_req)
                      - 3'(data_sram_data_ok);
         discard_cnt <= discard_cnt + 3'(disc_inc) - 3'(drop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_buf <= '0;
      end else if (live) begin
         rdata_buf <= data_sram_rdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_from_mem_r <= 1'b0;
         gr_we_r        <= 1'b0;
         dest_r         <= 5'd0;
         mem_type_r     <= 3'd0;
         addr_low_r     <= 3'd0;
         alu_r          <= '0;
         side_r         <= '0;
      end else if (accept) begin
         res_from_mem_r <= in_res_from_mem;
         gr_we_r        <= in_gr_we;
         dest_r         <= in_dest;
         mem_type_r     <= in_mem_type;
         addr_low_r     <= in_addr_low;
         alu_r          <= in_alu_result;
         side_r         <= in_side;
      end
   end

   logic [2:0]      addr_eff;
   logic [5:0]      shamt;
   logic [XLEN-1:0] sh;
   logic [XLEN-1:0] mask;
   logic            msb;
   logic [XLEN-1:0] ext;

   // Shift the addressed lane to bit 0, then extend with a width mask.
   always_comb begin
      addr_eff = (XLEN == 64) ? addr_low_r : {1'b0, addr_low_r[1:0]};
      shamt    = {addr_eff, 3'b000};
      sh       = rdata_buf >> shamt;
      mask     = '1;
      msb      = 1'b0;
      unique case (mem_type_r[1:0])
         2'b10: begin
            mask = XLEN'(8'hff);
            msb  = sh[7];
         end
         2'b01: begin
            mask = XLEN'(16'hffff);
            msb  = sh[15];
         end
         2'b00: begin
            mask = XLEN'(32'hffff_ffff);
            msb  = sh[31];
         end
         default: begin
            mask = '1;
            msb  = 1'b0;
         end
      endcase
      ext = (sh & mask) | ({XLEN{msb & ~mem_type_r[2]}} & ~mask);
   end

   assign out_gr_we        = gr_we_r;
   assign out_dest         = dest_r;
   assign out_side         = side_r;
   assign out_final_result = res_from_mem_r ? ext : alu_r;

   assign mem_fwd_valid = mem_valid & gr_we_r;
   assign mem_fwd_dest  = dest_r;
   assign mem_fwd_data  = out_final_result;
   assign mem_fwd_busy  = mem_valid & res_from_mem_r & (state == S_WAIT);

`ifdef MEM_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_wait_cycles <= 32'd0;
         perf_discards    <= 16'd0;
      end else begin
         if (mem_valid && state == S_WAIT && perf_wait_cycles != 32'hffff_ffff)
            perf_wait_cycles <= perf_wait_cycles + 32'd1;
         if (drop && perf_discards != 16'hffff)
            perf_discards <= perf_discards + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_resp_stage.sv
// tb_mem_resp_stage: directed vector table plus hand-written sequences
// for flush/discard, backpressure, WB stall and async reset.
module tb_mem_resp_stage;

   localparam int XLEN   = 32;
   localparam int SIDE_W = 112;

   logic              clk = 1'b0;
   logic              reset;
   logic              ex_mem_valid;
   logic              mem_allowin;
   logic              in_mem_req;
   logic              in_res_from_mem;
   logic              in_gr_we;
   logic [4:0]        in_dest;
   logic [2:0]        in_mem_type;
   logic [2:0]        in_addr_low;
   logic [XLEN-1:0]   in_alu_result;
   logic [SIDE_W-1:0] in_side;
   logic              data_sram_data_ok;
   logic [XLEN-1:0]   data_sram_rdata;
   logic              flush;
   logic              mem_wb_valid;
   logic              wb_allowin;
   logic              out_gr_we;
   logic [4:0]        out_dest;
   logic [XLEN-1:0]   out_final_result;
   logic [SIDE_W-1:0] out_side;
   logic              mem_fwd_valid;
   logic [4:0]        mem_fwd_dest;
   logic [XLEN-1:0]   mem_fwd_data;
   logic              mem_fwd_busy;
   logic [2:0]        outst_cnt;

   mem_resp_stage dut (
      .clk               (clk),
      .reset             (reset),
      .ex_mem_valid      (ex_mem_valid),
      .mem_allowin       (mem_allowin),
      .in_mem_req        (in_mem_req),
      .in_res_from_mem   (in_res_from_mem),
      .in_gr_we          (in_gr_we),
      .in_dest           (in_dest),
      .in_mem_type       (in_mem_type),
      .in_addr_low       (in_addr_low),
      .in_alu_result     (in_alu_result),
      .in_side           (in_side),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .flush             (flush),
      .mem_wb_valid      (mem_wb_valid),
      .wb_allowin        (wb_allowin),
      .out_gr_we         (out_gr_we),
      .out_dest          (out_dest),
      .out_final_result  (out_final_result),
      .out_side          (out_side),
      .mem_fwd_valid     (mem_fwd_valid),
      .mem_fwd_dest      (mem_fwd_dest),
      .mem_fwd_data      (mem_fwd_data),
      .mem_fwd_busy      (mem_fwd_busy),
      .outst_cnt         (outst_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int hs_cnt = 0;

   always @(posedge clk)
      if (!reset && mem_wb_valid && wb_allowin)
         hs_cnt <= hs_cnt + 1;

   typedef struct {
      logic        req;
      logic        res;
      logic [2:0]  mtype;
      logic [2:0]  alow;
      logic [31:0] rdata;
      logic [31:0] alu;
      int          dly;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      ex_mem_valid      = 1'b0;
      in_mem_req        = 1'b0;
      data_sram_data_ok = 1'b0;
      flush             = 1'b0;
   endtask

   task automatic present(input logic req, input logic res,
                          input logic [2:0] mt, input logic [2:0] al,
                          input logic [31:0] alu, input logic [4:0] dst);
      ex_mem_valid    = 1'b1;
      in_mem_req      = req;
      in_res_from_mem = res;
      in_gr_we        = 1'b1;
      in_dest         = dst;
      in_mem_type     = mt;
      in_addr_low     = al;
      in_alu_result   = alu;
      in_side         = {80'd0, alu};
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int busy;
      int h0;
      busy = 0;
      present(v.req, v.res, v.mtype, v.alow, v.alu, 5'(idx + 1));
      #1;
      check($sformatf("v%0d_allowin", idx), 32'(mem_allowin), 1);
      tick();
      ex_mem_valid = 1'b0;
      in_mem_req   = 1'b0;
      if (v.req) begin
         for (int i = 0; i < v.dly; i++) begin
            if (i == v.dly - 1) begin
               data_sram_data_ok = 1'b1;
               data_sram_rdata   = v.rdata;
            end
            #1;
            if (mem_fwd_busy) busy++;
            check($sformatf("v%0d_wait_wbv", idx), 32'(mem_wb_valid), 0);
            tick();
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'h0bad_f00d;
         end
      end
      check($sformatf("v%0d_busy_cycles", idx), busy,
            (v.req && v.res) ? v.dly : 0);
      #1;
      check($sformatf("v%0d_result", idx), out_final_result, v.exp);
      check($sformatf("v%0d_wbv", idx), 32'(mem_wb_valid), 1);
      check($sformatf("v%0d_fwd_valid", idx), 32'(mem_fwd_valid), 1);
      check($sformatf("v%0d_fwd_dest", idx), 32'(mem_fwd_dest), idx + 1);
      check($sformatf("v%0d_fwd_data", idx), mem_fwd_data, v.exp);
      check($sformatf("v%0d_side", idx), out_side[31:0], v.alu);
      h0 = hs_cnt;
      tick();
      check($sformatf("v%0d_wbv_after", idx), 32'(mem_wb_valid), 0);
      check($sformatf("v%0d_outst", idx), 32'(outst_cnt), 0);
      check($sformatf("v%0d_hs", idx), hs_cnt, h0 + 1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int h0;
      vec_t vf;

      //           req   res   type    alow  rdata          alu            dly exp
      vecs[0] = '{1'b1, 1'b1, 3'b010, 3'd3, 32'h80AB_CD12, 32'h0000_1003, 3, 32'hFFFF_FF80};
      vecs[1] = '{1'b1, 1'b1, 3'b101, 3'd2, 32'h9876_5432, 32'h0000_1002, 1, 32'h0000_9876};
      vecs[2] = '{1'b1, 1'b1, 3'b001, 3'd2, 32'h9876_5432, 32'h0000_1002, 2, 32'hFFFF_9876};
      vecs[3] = '{1'b1, 1'b1, 3'b000, 3'd0, 32'h1234_5678, 32'h0000_1000, 1, 32'h1234_5678};
      vecs[4] = '{1'b1, 1'b1, 3'b110, 3'd1, 32'h80AB_CD12, 32'h0000_1001, 2, 32'h0000_00CD};
      vecs[5] = '{1'b1, 1'b1, 3'b010, 3'd0, 32'h80AB_CD12, 32'h0000_1000, 1, 32'h0000_0012};
      vecs[6] = '{1'b1, 1'b1, 3'b001, 3'd0, 32'h80AB_CD12, 32'h0000_1000, 3, 32'hFFFF_CD12};
      vecs[7] = '{1'b0, 1'b0, 3'b000, 3'd0, 32'h0000_0000, 32'hCAFE_0001, 0, 32'hCAFE_0001};
      vecs[8] = '{1'b1, 1'b0, 3'b000, 3'd0, 32'h7777_7777, 32'h0000_0100, 2, 32'h0000_0100};

      reset           = 1'b1;
      wb_allowin      = 1'b1;
      in_res_from_mem = 1'b0;
      in_gr_we        = 1'b0;
      in_dest         = 5'd0;
      in_mem_type     = 3'd0;
      in_addr_low     = 3'd0;
      in_alu_result   = '0;
      in_side         = '0;
      data_sram_rdata = '0;
      idle_in();
      #1;
      check("rst_allowin", 32'(mem_allowin), 1);
      check("rst_wbv", 32'(mem_wb_valid), 0);
      check("rst_outst", 32'(outst_cnt), 0);
      check("rst_fwd_valid", 32'(mem_fwd_valid), 0);
      check("rst_busy", 32'(mem_fwd_busy), 0);
      check("rst_result", out_final_result, 0);
      check("rst_gr_we", 32'(out_gr_we), 0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Backpressure at MAX_OUTST with two orphaned responses pending.
      present(1'b1, 1'b1, 3'b000, 3'd0, 32'h10, 5'd3);
      tick();
      idle_in();
      flush = 1'b1;
      #1;
      check("bp_flush_allowin", 32'(mem_allowin), 0);
      tick();
      flush = 1'b0;
      #1;
      check("bp_outst1", 32'(outst_cnt), 1);
      check("bp_disc1", 32'(dut.discard_cnt), 1);
      present(1'b1, 1'b1, 3'b000, 3'd0, 32'h14, 5'd4);
      tick();
      idle_in();
      #1;
      check("bp_outst2", 32'(outst_cnt), 2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      check("bp_disc2", 32'(dut.discard_cnt), 2);
      present(1'b1, 1'b1, 3'b000, 3'd0, 32'h20, 5'd7);
      #1;
      check("bp_held_allowin", 32'(mem_allowin), 0);
      check("bp_held_outst", 32'(outst_cnt), 2);
      tick();
      #1;
      check("bp_held_allowin2", 32'(mem_allowin), 0);
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hAAAA_AAAA;
      tick();
      data_sram_data_ok = 1'b0;
      #1;
      check("bp_outst_drop", 32'(outst_cnt), 1);
      check("bp_disc_drop", 32'(dut.discard_cnt), 1);
      check("bp_allowin_free", 32'(mem_allowin), 1);
      tick();
      idle_in();
      #1;
      check("bp_third_outst", 32'(outst_cnt), 2);
      check("bp_third_busy", 32'(mem_fwd_busy), 1);
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hBBBB_BBBB;
      tick();
      data_sram_data_ok = 1'b0;
      #1;
      check("bp_disc0", 32'(dut.discard_cnt), 0);
      check("bp_still_busy", 32'(mem_fwd_busy), 1);
      check("bp_still_wbv", 32'(mem_wb_valid), 0);
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h5566_7788;
      tick();
      data_sram_data_ok = 1'b0;
      #1;
      check("bp_result", out_final_result, 32'h5566_7788);
      check("bp_wbv", 32'(mem_wb_valid), 1);
      check("bp_outst0", 32'(outst_cnt), 0);
      tick();

      // Flush a waiting load; stale response arrives later and is dropped.
      present(1'b1, 1'b1, 3'b000, 3'd0, 32'h40, 5'd9);
      tick();
      idle_in();
      tick();
      flush = 1'b1;
      present(1'b0, 1'b0, 3'b000, 3'd0, 32'h99, 5'd10);
      #1;
      check("fl_allowin", 32'(mem_allowin), 0);
      tick();
      idle_in();
      #1;
      check("fl_not_accepted", 32'(mem_wb_valid), 0);
      check("fl_disc1", 32'(dut.discard_cnt), 1);
      check("fl_outst1", 32'(outst_cnt), 1);
      tick();
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hDEAD_BEEF;
      tick();
      data_sram_data_ok = 1'b0;
      #1;
      check("fl_stale_disc0", 32'(dut.discard_cnt), 0);
      check("fl_stale_outst0", 32'(outst_cnt), 0);
      check("fl_stale_wbv", 32'(mem_wb_valid), 0);
      vf = '{1'b1, 1'b1, 3'b000, 3'd0, 32'h1234_5678, 32'h0000_2000, 2, 32'h1234_5678};
      run_vec(vf, 20);
      check("fl_disc_end", 32'(dut.discard_cnt), 0);

      // WB stalls for 4 cycles with a load in HAVE.
      present(1'b1, 1'b1, 3'b110, 3'd1, 32'h3001, 5'd11);
      tick();
      idle_in();
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h1122_3344;
      wb_allowin        = 1'b0;
      tick();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h0bad_f00d;
      h0 = hs_cnt;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("st%0d_wbv", i), 32'(mem_wb_valid), 1);
         check($sformatf("st%0d_result", i), out_final_result, 32'h33);
         check($sformatf("st%0d_allowin", i), 32'(mem_allowin), 0);
         tick();
      end
      check("st_no_hs", hs_cnt, h0);
      wb_allowin = 1'b1;
      #1;
      check("st_release_allowin", 32'(mem_allowin), 1);
      tick();
      #1;
      check("st_wbv_after", 32'(mem_wb_valid), 0);
      check("st_one_hs", hs_cnt, h0 + 1);

      // Asynchronous reset mid-WAIT with a discard pending.
      present(1'b1, 1'b1, 3'b000, 3'd0, 32'h50, 5'd12);
      tick();
      idle_in();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      present(1'b1, 1'b1, 3'b000, 3'd0, 32'h54, 5'd13);
      tick();
      idle_in();
      #1;
      check("ar_pre_busy", 32'(mem_fwd_busy), 1);
      check("ar_pre_outst", 32'(outst_cnt), 2);
      #2;
      reset = 1'b1;
      #1;
      check("ar_outst", 32'(outst_cnt), 0);
      check("ar_disc", 32'(dut.discard_cnt), 0);
      check("ar_valid", 32'(dut.mem_valid), 0);
      check("ar_allowin", 32'(mem_allowin), 1);
      check("ar_busy", 32'(mem_fwd_busy), 0);
      tick();
      reset = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
